// File: rtl/fetch_queue_if.sv
// Fetch queue bus: memory request/response handshake, redirect/hold control
// and the decode-side instruction output, bundled for the fetch_queue port list.
interface fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold;
  logic        address_enable;
  logic [31:0] address;
  logic        address_ready;
  logic        data_valid;
  logic [31:0] data;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        flushing;

  // master: the fetch queue itself; slave: core control + memory side
  modport master (
    input  redirect, redirect_pc, hold, address_ready, data_valid, data,
    output address_enable, address, out_valid, out_instruction, out_pc, flushing
  );
  modport slave (
    output redirect, redirect_pc, hold, address_ready, data_valid, data,
    input  address_enable, address, out_valid, out_instruction, out_pc, flushing
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues in-order word fetches, buffers responses
// with their pc, discards stale responses after a redirect.
// Optional macro FETCH_QUEUE_BYPASS_EN: response loads the output register directly when the queue is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP      = 32'h0
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {ACTIVE, FLUSHING} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t        state_q;
  logic          flushing_q;
  logic [CW-1:0] drop_q, redirect_drop;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] qwr_q, qwr_d, qrd_q, qrd_d;
  logic [AW-1:0] twr_q, twr_d, trd_q, trd_d;
  logic          ov_q, ov_d;
  logic [31:0]   oi_q, oi_d, op_q, op_d;

  entry_t        qmem [DEPTH];
  logic [31:0]   tmem [DEPTH];

  logic [CW:0]   occ;
  logic          ae, accept, resp, push, bypass, enq, pop;
  entry_t        resp_entry, head;

  // Any response arriving with nothing outstanding belongs to pre-reset traffic.
  assign resp   = bus.data_valid && (inflight_q != '0);
  assign occ    = {1'b0, count_q} + {1'b0, inflight_q};
  assign ae     = reset_n && !bus.redirect && (occ < DEPTH_W);
  assign accept = ae && bus.address_ready;
  assign push   = resp && (state_q == ACTIVE) && !bus.redirect;
  assign pop    = !bus.redirect && !bus.hold && (count_q != '0);
  assign head   = qmem[qrd_q];
  assign resp_entry = '{pc: tmem[trd_q], word: bus.data};
  assign redirect_drop = inflight_q - CW'(resp);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = push && (count_q == '0) && !bus.hold;
`else
  assign bypass = 1'b0;
`endif
  assign enq = push && !bypass;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(resp);
    count_d    = count_q;
    qwr_d      = qwr_q;
    qrd_d      = qrd_q;
    twr_d      = twr_q;
    trd_d      = trd_q;
    ov_d       = ov_q;
    oi_d       = oi_q;
    op_d       = op_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
      count_d = '0;
      qwr_d   = '0;
      qrd_d   = '0;
      twr_d   = '0;
      trd_d   = '0;
      ov_d    = 1'b0;
      oi_d    = NOP;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      count_d = count_q + CW'(enq) - CW'(pop);
      if (enq)    qwr_d = qwr_q + AW'(1);
      if (pop)    qrd_d = qrd_q + AW'(1);
      if (accept) twr_d = twr_q + AW'(1);
      if (push)   trd_d = trd_q + AW'(1);
      if (!bus.hold) begin
        if (pop) begin
          ov_d = 1'b1;
          oi_d = head.word;
          op_d = head.pc;
        end else if (bypass) begin
          ov_d = 1'b1;
          oi_d = resp_entry.word;
          op_d = resp_entry.pc;
        end else begin
          ov_d = 1'b0;
          oi_d = NOP;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      count_q    <= '0;
      qwr_q      <= '0;
      qrd_q      <= '0;
      twr_q      <= '0;
      trd_q      <= '0;
      ov_q       <= 1'b0;
      oi_q       <= NOP;
      op_q       <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      qwr_q      <= qwr_d;
      qrd_q      <= qrd_d;
      twr_q      <= twr_d;
      trd_q      <= trd_d;
      ov_q       <= ov_d;
      oi_q       <= oi_d;
      op_q       <= op_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clock) begin
    if (enq)    qmem[qwr_q] <= resp_entry;
    if (accept) tmem[twr_q] <= pc_q;
  end

  // Drop counter: stale responses still owed by memory after a redirect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ACTIVE;
      drop_q     <= '0;
      flushing_q <= 1'b0;
    end else if (bus.redirect) begin
      drop_q <= redirect_drop;
      if (redirect_drop != '0) begin
        state_q    <= FLUSHING;
        flushing_q <= 1'b1;
      end else begin
        state_q    <= ACTIVE;
        flushing_q <= 1'b0;
      end
    end else if (state_q == FLUSHING && resp) begin
      drop_q <= drop_q - CW'(1);
      if (drop_q == CW'(1)) begin
        state_q    <= ACTIVE;
        flushing_q <= 1'b0;
      end
    end
  end

  assign bus.address_enable  = ae;
  assign bus.address         = pc_q;
  assign bus.out_valid       = ov_q;
  assign bus.out_instruction = oi_q;
  assign bus.out_pc          = op_q;
  assign bus.flushing        = flushing_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: randomized memory latency/ready/hold/redirect
// against a queue-based reference model, plus directed scenario checks.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'hDEAD_BEEF;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fetch_queue_if bus();
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  // memory stimulus
  req_t        pend[$];
  int          lat = 1;
  int          cyc = 0;
  bit          dv_s;
  // reference model
  logic [31:0] m_pc, m_oi, m_op;
  bit          m_ov;
  int          m_stale;
  logic [31:0] m_tags[$];
  logic [63:0] m_q[$];
  // pre-edge samples
  logic        ae_s, exp_ae;
  logic [31:0] addr_s, exp_addr;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ (a << 7);
  endfunction

  function automatic logic [98:0] obs_v();
    return {ae_s, ae_s ? addr_s : 32'h0, bus.flushing, bus.out_valid,
            bus.out_instruction, bus.out_valid ? bus.out_pc : 32'h0};
  endfunction

  function automatic logic [98:0] exp_v();
    return {exp_ae, exp_ae ? exp_addr : 32'h0, m_stale > 0, m_ov,
            m_oi, m_ov ? m_op : 32'h0};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_stale = 0; m_ov = 1'b0; m_oi = NOP; m_op = 32'h0;
    m_tags.delete(); m_q.delete();
  endtask

  task automatic model_edge(input bit dv_in, input logic [31:0] d);
    int infl; bit dv, acc, have_e; logic [31:0] e_pc; logic [63:0] h;
    infl = m_stale + m_tags.size();
    dv = dv_in && infl > 0;
    acc = !bus.redirect && (m_q.size() + infl < DEPTH) && bus.address_ready;
    have_e = 1'b0; e_pc = 32'h0;
    if (bus.redirect) begin
      m_stale = infl - int'(dv);
      m_tags.delete(); m_q.delete();
      m_ov = 1'b0; m_oi = NOP;
      m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (dv) begin
        if (m_stale > 0) m_stale--;
        else begin e_pc = m_tags.pop_front(); have_e = 1'b1; end
      end
      if (!bus.hold) begin
        if (m_q.size() > 0) begin h = m_q.pop_front(); m_op = h[63:32]; m_oi = h[31:0]; m_ov = 1'b1; end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (have_e) begin m_op = e_pc; m_oi = d; m_ov = 1'b1; have_e = 1'b0; end
`endif
        else begin m_ov = 1'b0; m_oi = NOP; end
      end
      if (have_e) m_q.push_back({e_pc, d});
      if (acc) begin m_tags.push_back(m_pc); m_pc = m_pc + 32'd4; end
    end
  endtask

  // One clock: drive memory response, sample pre-edge, advance model, land on next negedge.
  task automatic step();
    req_t r; int due;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      bus.data_valid = 1'b1; bus.data = word(r.addr);
    end else begin
      bus.data_valid = 1'b0; bus.data = $urandom;
    end
    dv_s = bus.data_valid;
    #1;
    ae_s = bus.address_enable; addr_s = bus.address;
    exp_ae = !bus.redirect && (m_q.size() + m_stale + m_tags.size() < DEPTH);
    exp_addr = m_pc;
    if (ae_s && bus.address_ready) begin
      due = cyc + lat;
      if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
      pend.push_back('{bus.address, due});
    end
    model_edge(bus.data_valid, bus.data);
    @(posedge clock); @(negedge clock);
    cyc++;
  endtask

  task automatic drain();
    int k;
    bus.address_ready = 1'b0; bus.hold = 1'b0; bus.redirect = 1'b0;
    for (k = 0; k < 60; k++) begin
      if (pend.size() == 0 && m_q.size() == 0 && m_tags.size() == 0 && m_stale == 0 && !m_ov) break;
      step();
    end
    n_chk++;
    if (k >= 60) begin n_fail++; $display("FAIL drain_timeout pend=%0d", pend.size()); end
  endtask

  task automatic test_reset();
    bus.redirect = 0; bus.redirect_pc = 0; bus.hold = 0; bus.address_ready = 0;
    bus.data_valid = 0; bus.data = 0;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.address_enable, bus.out_valid, bus.flushing} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl got=%b exp=000", {bus.address_enable, bus.out_valid, bus.flushing});
    end
    repeat (2) @(negedge clock);
    n_chk++;
    if (bus.out_instruction !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", bus.out_instruction, NOP); end
    n_chk++;
    if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", bus.out_pc); end
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (bus.address_enable !== 1'b1 || bus.address !== RESET_PC) begin
      n_fail++; $display("FAIL reset_release ae=%b addr=%h exp 1/%h", bus.address_enable, bus.address, RESET_PC);
    end
    model_reset();
  endtask

  task automatic test_stream();
    int k; bit seen; int gaps;
    k = 0; seen = 0; gaps = 0;
    lat = 1; bus.address_ready = 1; bus.hold = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i < 4) begin
        n_chk++;
        if (addr_s !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_addr got=%h exp=%h", addr_s, 32'(4 * i)); end
      end
      n_chk++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL stream_model cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (bus.out_valid) begin
        if (k < 4) begin
          n_chk++;
          if ({bus.out_pc, bus.out_instruction} !== {32'(4 * k), word(32'(4 * k))}) begin
            n_fail++; $display("FAIL stream_out got=%h/%h exp=%h", bus.out_pc, bus.out_instruction, 32'(4 * k));
          end
        end
        k++; seen = 1;
      end else if (seen) gaps++;
    end
    n_chk++;
    if (gaps != 0 || k < 4) begin n_fail++; $display("FAIL stream_gaps got=%0d/%0d exp=0/>=4", gaps, k); end
  endtask

  task automatic test_hold();
    logic [31:0] held_oi, prev; bit held_ov, have_prev;
    drain();
    lat = 1; bus.address_ready = 1; bus.hold = 0;
    repeat (3) step();
    held_oi = m_oi; held_ov = m_ov; have_prev = m_ov; prev = m_op;
    bus.hold = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL hold_model cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
    end
    n_chk++;
    if (ae_s !== 1'b0) begin n_fail++; $display("FAIL hold_ae got=%b exp=0", ae_s); end
    n_chk++;
    if ({bus.out_valid, bus.out_instruction} !== {held_ov, held_oi}) begin
      n_fail++; $display("FAIL hold_out got=%b/%h exp=%b/%h", bus.out_valid, bus.out_instruction, held_ov, held_oi);
    end
    bus.hold = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL hold_rel_model cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (bus.out_valid) begin
        if (have_prev) begin
          n_chk++;
          if ({bus.out_pc, bus.out_instruction} !== {prev + 32'd4, word(prev + 32'd4)}) begin
            n_fail++; $display("FAIL hold_order got=%h exp=%h", bus.out_pc, prev + 32'd4);
          end
        end
        prev = bus.out_pc; have_prev = 1;
      end
    end
  endtask

  task automatic test_redirect();
    int drop_exp, rs; bit got_first;
    drain();
    lat = 4; bus.address_ready = 1; bus.hold = 0;
    for (int i = 0; i < 10 && pend.size() < 3; i++) step();
    n_chk++;
    if (pend.size() != 3) begin n_fail++; $display("FAIL redir_setup got=%0d exp=3", pend.size()); end
    drop_exp = pend.size() - ((pend.size() > 0 && pend[0].due <= cyc) ? 1 : 0);
    bus.redirect = 1; bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 0;
    n_chk++;
    if ({bus.flushing, bus.out_valid} !== {drop_exp > 0, 1'b0}) begin
      n_fail++; $display("FAIL redir_enter got=%b%b exp=%b0", bus.flushing, bus.out_valid, drop_exp > 0);
    end
    rs = 0; got_first = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (dv_s) rs++;
      n_chk++;
      if (bus.flushing !== (rs < drop_exp)) begin n_fail++; $display("FAIL redir_flushing got=%b exp=%b", bus.flushing, rs < drop_exp); end
      n_chk++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL redir_model cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
      if (bus.out_valid && !got_first) begin
        got_first = 1;
        n_chk++;
        if ({bus.out_pc, bus.out_instruction} !== {32'h100, word(32'h100)}) begin
          n_fail++; $display("FAIL redir_first got=%h exp=00000100", bus.out_pc);
        end
      end
    end
    n_chk++;
    if (!got_first) begin n_fail++; $display("FAIL redir_no_output got=0 exp=1"); end
  endtask

  task automatic test_redirect_dv_hold();
    int drop_exp, rs;
    drain();
    lat = 1; bus.address_ready = 1; bus.hold = 0;
    repeat (4) step();
    bus.hold = 1;
    step();
    n_chk++;
    if (!(pend.size() > 0 && pend[0].due <= cyc)) begin n_fail++; $display("FAIL rdh_setup got=0 exp=1"); end
    drop_exp = pend.size() - 1;
    bus.redirect = 1; bus.redirect_pc = 32'h240;
    step();
    bus.redirect = 0; bus.hold = 0; bus.address_ready = 0;
    n_chk++;
    if ({bus.out_valid, bus.out_instruction, bus.flushing} !== {1'b0, NOP, drop_exp > 0}) begin
      n_fail++; $display("FAIL rdh_edge got=%b/%h/%b exp=0/%h/%b", bus.out_valid, bus.out_instruction, bus.flushing, NOP, drop_exp > 0);
    end
    rs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dv_s) rs++;
      n_chk++;
      if ({bus.flushing, bus.out_valid} !== {rs < drop_exp, 1'b0}) begin
        n_fail++; $display("FAIL rdh_drop got=%b%b exp=%b0", bus.flushing, bus.out_valid, rs < drop_exp);
      end
    end
  endtask

  task automatic test_ready_toggle();
    logic [31:0] tpc;
    drain();
    bus.hold = 0; tpc = m_pc;
    for (int i = 0; i < 60; i++) begin
      bus.address_ready = cyc[0];
      lat = $urandom_range(1, 3);
      step();
      if (ae_s) begin
        n_chk++;
        if (addr_s !== tpc) begin n_fail++; $display("FAIL toggle_addr got=%h exp=%h", addr_s, tpc); end
        if (bus.address_ready) tpc = tpc + 32'd4;
      end
      n_chk++;
      if (pend.size() > DEPTH) begin n_fail++; $display("FAIL toggle_inflight got=%0d exp<=%0d", pend.size(), DEPTH); end
      n_chk++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL toggle_model cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.hold = ($urandom_range(0, 9) < 3);
      bus.address_ready = ($urandom_range(0, 9) < 7);
      bus.redirect = ($urandom_range(0, 99) < 4);
      bus.redirect_pc = $urandom;
      lat = $urandom_range(1, 4);
      step();
      n_chk++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
    end
    bus.redirect = 0;
  endtask

  task automatic test_reset_mid();
    int k;
    lat = 3; bus.address_ready = 1; bus.hold = 0;
    repeat (6) step();
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.address_enable, bus.out_valid, bus.flushing, bus.out_instruction} !== {3'b000, NOP}) begin
      n_fail++; $display("FAIL rstmid_async got=%b%b%b/%h exp=000/%h", bus.address_enable, bus.out_valid, bus.flushing, bus.out_instruction, NOP);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    bus.address_ready = 0;
    for (k = 0; k < 20 && pend.size() > 0; k++) begin
      step();
      n_chk++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL rstmid_stale cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
    end
    bus.address_ready = 1; lat = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) begin
        n_chk++;
        if (addr_s !== RESET_PC) begin n_fail++; $display("FAIL rstmid_addr got=%h exp=%h", addr_s, RESET_PC); end
      end
      n_chk++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v()); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] a;
    drain();
    lat = 1; bus.hold = 0; bus.address_ready = 1;
    a = m_pc;
    step();
    bus.address_ready = 0;
    n_chk++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge0 got=%b exp=0", bus.out_valid); end
    step();
    n_chk++;
    if (bus.out_valid !== BYP) begin n_fail++; $display("FAIL lat_edge1 got=%b exp=%b", bus.out_valid, BYP); end
    if (!BYP) step();
    n_chk++;
    if ({bus.out_valid, bus.out_pc, bus.out_instruction} !== {1'b1, a, word(a)}) begin
      n_fail++; $display("FAIL lat_out got=%b/%h exp=1/%h", bus.out_valid, bus.out_pc, a);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_redirect();
    test_redirect_dv_hold();
    test_ready_toggle();
    test_random();
    test_reset_mid();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
